// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, a single-entry
// instruction register towards decode, and flush redirection that drains
// a request still in flight before fetching from the new PC.
module fetch_unit #(
    parameter int unsigned PC_W    = 16,
    parameter int unsigned INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PC_W-1:0]    pc,
    output logic               pc_we,
    output logic [PC_W-1:0]    pc_next,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               flush,
    input  logic [PC_W-1:0]    flush_target,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [INSTR_W-1:0] ir_data,
    output logic [PC_W-1:0]    ir_pc
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] OUT   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [INSTR_W-1:0] ir_data_nxt;
    logic [PC_W-1:0]    ir_pc_nxt;
    logic [PC_W-1:0]    drain_addr;
    logic [PC_W-1:0]    drain_addr_nxt;

    // State and instruction-register update; reset abandons everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= FETCH;
            ir_valid   <= 1'b0;
            ir_data    <= '0;
            ir_pc      <= '0;
            drain_addr <= '0;
        end else begin
            state      <= state_nxt;
            ir_valid   <= (state_nxt == OUT);
            ir_data    <= ir_data_nxt;
            ir_pc      <= ir_pc_nxt;
            drain_addr <= drain_addr_nxt;
        end
    end

    // Next state, memory request and PC update; flush outranks ack and ready.
    always_comb begin
        state_nxt      = state;
        ir_data_nxt    = ir_data;
        ir_pc_nxt      = ir_pc;
        drain_addr_nxt = drain_addr;
        pc_we          = 1'b0;
        pc_next        = pc;
        imem_req       = 1'b0;
        imem_addr      = pc;

        case (state)
            FETCH: begin
                imem_req  = 1'b1;
                imem_addr = pc;
                if (flush) begin
                    pc_we   = 1'b1;
                    pc_next = flush_target;
                    // Request still in flight: remember its address and drain it.
                    if (!imem_ack) begin
                        drain_addr_nxt = pc;
                        state_nxt      = DRAIN;
                    end
                end else if (imem_ack) begin
                    ir_data_nxt = imem_rdata;
                    ir_pc_nxt   = pc;
                    pc_we       = 1'b1;
                    pc_next     = pc + PC_W'(1);
                    state_nxt   = OUT;
                end
            end
            OUT: begin
                if (flush) begin
                    pc_we     = 1'b1;
                    pc_next   = flush_target;
                    state_nxt = FETCH;
                end else if (ir_ready) begin
                    state_nxt = FETCH;
                end
            end
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr;
                if (flush) begin
                    pc_we   = 1'b1;
                    pc_next = flush_target;
                end else if (imem_ack) begin
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase

        // No memory traffic or PC writes while reset is held.
        if (!reset) begin
            imem_req = 1'b0;
            pc_we    = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios followed by random traffic,
// checked by a scoreboard fed from an instruction-stream reference model.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [15:0] pc;
    logic        pc_we;
    logic [15:0] pc_next;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        flush;
    logic [15:0] flush_target;
    logic        ir_valid;
    logic        ir_ready;
    logic [15:0] ir_data;
    logic [15:0] ir_pc;

    logic        pc_load;
    logic [15:0] pc_load_val;
    logic        mon_en;

    int checks;
    int errors;
    int delivered;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] data;
    } item_t;

    // Reference model state: architectural fetch PC, instructions owed to
    // decode, and whether the outstanding memory request is a stale one.
    item_t       sb_q[$];
    logic [15:0] model_pc;
    logic        stale;
    logic [15:0] stale_addr;
    logic        after_rst;

    fetch_unit #(.PC_W(16), .INSTR_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .pc_we        (pc_we),
        .pc_next      (pc_next),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .flush        (flush),
        .flush_target (flush_target),
        .ir_valid     (ir_valid),
        .ir_ready     (ir_ready),
        .ir_data      (ir_data),
        .ir_pc        (ir_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External PC register; the bench can preload it.
    always @(posedge clk) begin
        if (pc_load)
            pc <= pc_load_val;
        else if (pc_we)
            pc <= pc_next;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: compare DUT outputs against the model, then advance it.
    always @(negedge clk) begin
        logic        held;
        logic        exp_we;
        item_t       it;
        if (mon_en) begin
            held = (sb_q.size() != 0);
            if (!reset) begin
                chk("rst_imem_req", 32'(imem_req), 32'd0);
                chk("rst_pc_we", 32'(pc_we), 32'd0);
                chk("rst_ir_valid", 32'(ir_valid), 32'(held));
                sb_q.delete();
                stale     = 1'b0;
                after_rst = 1'b1;
                if (pc_load)
                    model_pc = pc_load_val;
            end else begin
                if (after_rst)
                    chk("post_rst_req", 32'(imem_req), 32'd1);
                after_rst = 1'b0;
                chk("ir_valid", 32'(ir_valid), 32'(held));
                chk("imem_req", 32'(imem_req), 32'(!held));
                if (!held) begin
                    chk("imem_addr", 32'(imem_addr), 32'(stale ? stale_addr : model_pc));
                end else begin
                    chk("ir_data", 32'(ir_data), 32'(sb_q[0].data));
                    chk("ir_pc", 32'(ir_pc), 32'(sb_q[0].pc));
                end
                exp_we = flush || (!held && imem_ack && !stale);
                chk("pc_we", 32'(pc_we), 32'(exp_we));
                if (exp_we)
                    chk("pc_next", 32'(pc_next),
                        32'(flush ? flush_target : 16'(model_pc + 16'd1)));

                if (flush) begin
                    if (held)
                        void'(sb_q.pop_front());
                    else if (!stale && !imem_ack) begin
                        stale      = 1'b1;
                        stale_addr = model_pc;
                    end
                    model_pc = flush_target;
                end else if (held) begin
                    if (ir_ready) begin
                        void'(sb_q.pop_front());
                        delivered++;
                    end
                end else if (imem_ack) begin
                    if (stale) begin
                        stale = 1'b0;
                    end else begin
                        it.pc   = model_pc;
                        it.data = imem_rdata;
                        sb_q.push_back(it);
                        model_pc = 16'(model_pc + 16'd1);
                    end
                end
            end
        end
    end

    task automatic step(input logic r, input logic a, input logic [15:0] d,
                        input logic f, input logic [15:0] t, input logic rdy);
        @(posedge clk);
        #1;
        mon_en       = 1'b1;
        pc_load      = 1'b0;
        reset        = r;
        imem_ack     = a;
        imem_rdata   = d;
        flush        = f;
        flush_target = t;
        ir_ready     = rdy;
    endtask

    task automatic reset_load(input logic [15:0] v);
        step(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        pc_load     = 1'b1;
        pc_load_val = v;
    endtask

    initial begin
        checks = 0; errors = 0; delivered = 0;
        model_pc = 16'h0; stale = 1'b0; stale_addr = 16'h0; after_rst = 1'b0;
        mon_en = 1'b0; pc_load = 1'b0; pc_load_val = 16'h0;
        reset = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0;
        flush = 1'b0; flush_target = 16'h0; ir_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);

        // Zero-wait stream from 0000: A1, A2, A3
        reset_load(16'h0000);
        step(1, 1, 16'h00A1, 0, 16'h0, 1);
        step(1, 1, 16'h0000, 0, 16'h0, 1);
        step(1, 1, 16'h00A2, 0, 16'h0, 1);
        step(1, 1, 16'h0000, 0, 16'h0, 1);
        step(1, 1, 16'h00A3, 0, 16'h0, 1);
        step(1, 1, 16'h0000, 0, 16'h0, 1);

        // Backpressure: hold 1234 for five cycles
        step(1, 1, 16'h1234, 0, 16'h0, 0);
        for (int i = 0; i < 5; i++)
            step(1, 0, 16'h0, 0, 16'h0, 0);
        step(1, 0, 16'h0, 0, 16'h0, 1);

        // Wait states plus wrap at FFFF
        reset_load(16'hFFFF);
        for (int i = 0; i < 3; i++)
            step(1, 0, 16'h0, 0, 16'h0, 1);
        step(1, 1, 16'hBEEF, 0, 16'h0, 1);
        step(1, 0, 16'h0, 0, 16'h0, 1);

        // Flush in OUT to 0040
        step(1, 1, 16'h5555, 0, 16'h0, 0);
        step(1, 0, 16'h0, 1, 16'h0040, 1);
        step(1, 1, 16'h4040, 0, 16'h0, 1);
        step(1, 0, 16'h0, 0, 16'h0, 1);

        // Flush during wait at 0010, ack two cycles later
        reset_load(16'h0010);
        step(1, 0, 16'h0, 1, 16'h0080, 1);
        step(1, 0, 16'h0, 0, 16'h0, 1);
        step(1, 1, 16'hDEAD, 0, 16'h0, 1);
        step(1, 1, 16'h8080, 0, 16'h0, 1);
        step(1, 0, 16'h0, 0, 16'h0, 1);

        // Reset while draining
        step(1, 0, 16'h0, 1, 16'h0100, 1);
        step(1, 0, 16'h0, 0, 16'h0, 1);
        step(0, 0, 16'h0, 0, 16'h0, 1);
        step(1, 1, 16'h0101, 0, 16'h0, 1);
        step(1, 0, 16'h0, 0, 16'h0, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(199) != 0),
                 ($urandom_range(1) == 1),
                 16'($urandom),
                 ($urandom_range(11) == 0),
                 16'($urandom),
                 ($urandom_range(4) < 3));
        end
        step(1, 0, 16'h0, 0, 16'h0, 1);
        @(posedge clk);
        mon_en = 1'b0;

        chk("progress", 32'(delivered >= 100), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be, one per line:
  - PC_W, 16, program-counter and instruction-address width.
  - INSTR_W, 16, instruction word width.
REQ-002 Ports SHALL be, one per line:
  - clk  in  1  single clock; all state updates on rising edge.
  - reset  in  1  synchronous, active-low reset (reset==0 at a rising clk edge resets the block).
  - pc  in  PC_W  current PC from the pc register.
  - pc_we  out  1  PC write enable to the pc register.
  - pc_next  out  PC_W  next PC value to the pc register.
  - imem_req  out  1  instruction-memory request.
  - imem_addr  out  PC_W  word address of the request.
  - imem_ack  in  1  memory returns data this cycle.
  - imem_rdata  in  INSTR_W  instruction word, valid when imem_ack=1.
  - flush  in  1  redirect from execute (branch/jump taken).
  - flush_target  in  PC_W  redirect PC, valid when flush=1.
  - ir_valid  out  1  instruction available to decode.
  - ir_ready  in  1  decode accepts the instruction.
  - ir_data  out  INSTR_W  fetched instruction.
  - ir_pc  out  PC_W  address ir_data was fetched from.

Function
REQ-003 The FSM SHALL have exactly three states: FETCH, OUT and DRAIN.
REQ-004 At most one memory request SHALL be outstanding; imem_req and imem_addr SHALL stay stable from assertion until the cycle imem_ack=1.
REQ-005 In FETCH, outputs SHALL be imem_req=1 and imem_addr=pc.
REQ-006 In FETCH, on imem_ack=1 with flush=0:
  - latch ir_data<=imem_rdata and ir_pc<=pc;
  - drive pc_we=1 and pc_next=pc+1 (modulo 2^PC_W, so FFFF wraps to 0000) in that same cycle;
  - go to OUT.
REQ-007 In OUT, outputs SHALL be ir_valid=1 and imem_req=0. ir_data and ir_pc SHALL hold while ir_valid=1 and ir_ready=0.
REQ-008 In OUT, on ir_ready=1 with flush=0, the block SHALL go to FETCH; ir_valid deasserts the next cycle. Minimum fetch latency SHALL be one cycle from request to ir_valid. Throughput SHALL be one instruction per two cycles with a zero-wait memory.
REQ-009 pc_we SHALL be 0 in every cycle not covered by REQ-006 or REQ-010.
REQ-010 flush=1 SHALL take priority over imem_ack and ir_ready; in that cycle the block SHALL drive pc_we=1 and pc_next=flush_target.
REQ-011 Flush in OUT SHALL discard the held instruction (ir_valid=0 next cycle) and go to FETCH.
REQ-012 Flush in FETCH with imem_ack=1 SHALL discard imem_rdata and stay in FETCH.
REQ-013 Flush in FETCH with imem_ack=0 SHALL:
  - latch drain_addr<=pc;
  - go to DRAIN.
REQ-014 In DRAIN, outputs SHALL be imem_req=1 and imem_addr=drain_addr. On imem_ack, the block SHALL discard the data and go to FETCH.
REQ-015 In DRAIN, a further flush SHALL update the PC per REQ-010 and the block SHALL remain in DRAIN.
REQ-016 ir_valid SHALL be 1 only in OUT; imem_req SHALL be 1 only in FETCH or DRAIN.

Reset
REQ-017 While reset==0 at a clock edge, the next-cycle values SHALL be:
  - state=FETCH, ir_valid=0, ir_data=0, ir_pc=0, drain_addr=0.
REQ-018 While reset==0, outputs SHALL be imem_req=0 and pc_we=0, regardless of other inputs.
REQ-019 Reset asserted in any state, including DRAIN mid-request, SHALL abandon all state. The memory SHALL drop any pending request on reset.
REQ-020 In the first cycle after reset deasserts, the block SHALL be in FETCH with imem_req=1.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
  - Zero-wait stream: pc=0000, ack every request, ir_ready=1, rdata=A1,A2,A3 -> ir_data A1,A2,A3; ir_pc 0,1,2; pc_we pulses once per instruction; ir_valid every 2nd cycle.
  - Backpressure: ir_ready=0 for 5 cycles with ir_data=1234 -> ir_valid=1 and ir_data=1234 held stable; no imem_req; pc_we=0.
  - Wait states plus wrap: pc=FFFF, ack after 3 cycles -> imem_addr=FFFF held for 3 cycles, then pc_next=0000 with pc_we=1.
  - Flush in OUT: flush_target=0040 -> pc_next=0040, pc_we=1; ir_valid=0 next cycle; next imem_addr=0040.
  - Flush during wait: flush at pc=0010 with ack arriving 2 cycles later -> imem_addr stays 0010 until ack; data discarded; then request at flush_target; ir_valid never asserts for 0010.
  - Reset mid-DRAIN: reset=0 for one cycle -> ir_valid=0 and imem_req=0 during reset; FETCH with imem_req=1 on the first cycle after release.
